// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing states, constants and reflected CRC-32 byte update
package eth_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] p;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) p[i] = CRC_POLY[31-i];
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ p : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/byte2rgmii.sv
// byte2rgmii: same-edge DDR output registers turning a byte plus TX_EN/TX_ER into RGMII pins
module byte2rgmii (
  input  logic       eth_txc,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       en,
  input  logic       er,
  output logic [3:0] txd,
  output logic       ctl
);
  logic [3:0] lo, hi;
  logic ctl_r, ctl_f;
  always_ff @(posedge eth_txc) begin
    if (rst) begin
      lo <= 4'd0;
      hi <= 4'd0;
      ctl_r <= 1'b0;
      ctl_f <= 1'b0;
    end else begin
      lo <= data[3:0];
      hi <= data[7:4];
      ctl_r <= en;
      ctl_f <= en ^ er;
    end
  end
  assign txd = eth_txc ? lo : hi;
  assign ctl = eth_txc ? ctl_r : ctl_f;
endmodule

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: frames a byte stream with preamble, SFD, zero pad, CRC-32 FCS and IFG onto RGMII
module rgmii_tx_framer
  import eth_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       eth_txc,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [3:0] eth_txd,
  output logic       eth_tx_ctl,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun
);
  state_t state;
  logic [10:0] len, idx, len_inc;
  logic [31:0] crc;
  logic [7:0] txb, fcs_byte;
  logic tx_en, tx_er;
  always_comb begin
    len_inc = &len ? len : len + 11'd1;
    fcs_byte = ~crc[{idx[1:0], 3'b000} +: 8];
    tx_ready = state == S_DATA;
    tx_busy = state != S_IDLE;
    underrun = tx_ready && !tx_valid;
    frame_done = state == S_IFG && idx == 11'(IFG_BYTES - 1);
  end
  always_ff @(posedge eth_txc) begin
    if (rst) begin
      state <= S_IDLE;
      len <= 11'd0;
      idx <= 11'd0;
      crc <= CRC_INIT;
      txb <= 8'h00;
      tx_en <= 1'b0;
      tx_er <= 1'b0;
    end else begin
      txb <= 8'h00;
      tx_en <= 1'b0;
      tx_er <= 1'b0;
      case (state)
        S_IDLE: if (tx_valid) state <= S_PREAMBLE;
        S_PREAMBLE: begin
          txb <= PREAMBLE_BYTE;
          tx_en <= 1'b1;
          idx <= idx == 11'd6 ? 11'd0 : idx + 11'd1;
          if (idx == 11'd6) state <= S_SFD;
        end
        S_SFD: begin
          txb <= SFD_BYTE;
          tx_en <= 1'b1;
          len <= 11'd0;
          crc <= CRC_INIT;
          state <= S_DATA;
        end
        S_DATA: begin
          tx_en <= 1'b1;
          if (tx_valid) begin
            txb <= tx_data;
            crc <= crc32_byte(crc, tx_data);
            len <= len_inc;
            if (tx_last) state <= len_inc < 11'(MIN_FRAME) ? S_PAD : S_FCS;
          end else begin
            tx_er <= 1'b1;
            state <= S_IFG;
          end
        end
        S_PAD: begin
          tx_en <= 1'b1;
          crc <= crc32_byte(crc, 8'h00);
          len <= len_inc;
          if (len_inc == 11'(MIN_FRAME)) state <= S_FCS;
        end
        S_FCS: begin
          txb <= fcs_byte;
          tx_en <= 1'b1;
          idx <= idx == 11'd3 ? 11'd0 : idx + 11'd1;
          if (idx == 11'd3) state <= S_IFG;
        end
        S_IFG: begin
          idx <= frame_done ? 11'd0 : idx + 11'd1;
          if (frame_done) state <= tx_valid ? S_PREAMBLE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  byte2rgmii u_ddr (
    .eth_txc(eth_txc),
    .rst(rst),
    .data(txb),
    .en(tx_en),
    .er(tx_er),
    .txd(eth_txd),
    .ctl(eth_tx_ctl)
  );
endmodule

// File: doc/rgmii_tx_framer.md
RGMII_TX_FRAMER -- requirements
Module: rgmii_tx_framer

Interface
REQ-001 Parameter IFG_BYTES, default 12: idle byte-times inserted after every frame.
REQ-002 Parameter MIN_FRAME, default 60: minimum DA-to-payload length in bytes before FCS; shorter frames are zero-padded.
REQ-003 eth_txc  in  1  single byte clock (125 MHz); all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 tx_data  in  8  frame byte, DA first, FCS excluded.
REQ-006 tx_valid  in  1  tx_data valid.
REQ-007 tx_last  in  1  marks the final byte of the frame; qualified by tx_valid.
REQ-008 tx_ready  out  1  framer accepts tx_data this cycle.
REQ-009 eth_txd  out  4  RGMII DDR data; low nibble on the rising edge, high nibble on the falling edge.
REQ-010 eth_tx_ctl  out  1  RGMII DDR control; TX_EN on the rising edge, TX_EN XOR TX_ER on the falling edge.
REQ-011 tx_busy  out  1  high in every state except IDLE.
REQ-012 frame_done  out  1  one-cycle pulse on the last IFG cycle.
REQ-013 underrun  out  1  one-cycle pulse when a frame is aborted for missing data.

Function
REQ-014 States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-015 IDLE -> PREAMBLE when tx_valid=1; no byte is consumed in IDLE.
REQ-016 PREAMBLE emits 7 bytes of 0x55; SFD emits 1 byte of 0xD5.
REQ-017 tx_ready=1 only in DATA; a transfer occurs when tx_valid & tx_ready; each transferred byte is emitted with TX_EN=1.
REQ-018 In DATA, tx_valid=0 -> underrun: emit one byte 0x00 with TX_EN=1 and TX_ER=1, pulse underrun, go to IFG; frame_done still pulses.
REQ-019 Transfer with tx_last=1: go to PAD if the byte count (including this byte) < MIN_FRAME, else to FCS.
REQ-020 PAD emits 0x00 bytes until the byte count equals MIN_FRAME, then goes to FCS.
REQ-021 The byte counter is 11 bits and saturates at 2047; frame length is not limited.
REQ-022 CRC-32 uses polynomial 0x04C11DB7, reflected input/output, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, and covers DA through pad.
REQ-023 FCS emits 4 bytes, least-significant byte first, then goes to IFG.
REQ-024 IFG holds TX_EN=0 and TX_ER=0 for IFG_BYTES cycles, then returns to IDLE.
REQ-025 A frame pending during IFG waits; tx_ready stays 0.
REQ-026 Latency: tx_valid seen in IDLE at cycle T -> internal byte registered at T+1 -> first preamble nibble on the pins during T+2; the same pipeline depth applies to every byte.
REQ-027 The internal byte, TX_EN and TX_ER are registered; pins are driven only by the DDR output stage.
REQ-028 When idle, eth_txd=0 and eth_tx_ctl=0 on both edges.

Reset
REQ-029 Reset drives: state IDLE, counters 0, CRC 0xFFFFFFFF, tx_ready=0, tx_busy=0, frame_done=0, underrun=0, internal byte/TX_EN/TX_ER=0, and eth_txd/eth_tx_ctl=0 on the next edge.
REQ-030 Reset mid-frame truncates the frame without an error code and without an IFG; no underrun or frame_done pulse is generated.

Structure
REQ-031 A shared package eth_pkg holds the state enum, constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT, CRC_POLY, and a function crc32_byte(crc, data) for reuse by the receive-side checker.
REQ-032 Sub-module byte2rgmii wraps five same-edge DDR output registers (4 data, 1 ctl) clocked by eth_txc; it has no reset beyond the register reset.

Verification
REQ-033 crc32_byte applied over ASCII "123456789" -> final CRC 0xCBF43926, emitted as bytes 0x26,0x39,0xF4,0xCB.
REQ-034 64-byte frame of 0x00..0x3F with valid held high -> decoded stream is 7x0x55, 0xD5, 64 payload bytes, 4 FCS bytes matching the bench model, then 12 idle cycles; tx_ready high for exactly 64 cycles.
REQ-035 1-byte frame 0xAB -> 0xAB followed by 59 bytes of 0x00, then FCS over all 60 bytes; total TX_EN duration is 72 cycles.
REQ-036 tx_valid dropped after byte 10 of 100 -> the 11th byte is 0x00 with eth_tx_ctl 1 then 0 across the clock period, underrun pulses once, then 12 idle cycles and frame_done.
REQ-037 Back-to-back frames with tx_valid held high -> exactly 12 idle cycles between the last FCS byte and the next 0x55.
REQ-038 rst asserted during payload byte 20 -> the next cycle shows eth_tx_ctl=0; after release, a new frame starts with a full preamble and correct FCS.
